// File: rtl/prog_clk_gen.sv
// Programmable clock/enable generator: divides clk by a run-time ratio, with square, PWM and
// one-shot modes. New configs go into a shadow and become active only at period boundaries.
module prog_clk_gen #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned DEF_DIV  = 4,
    parameter int unsigned DEF_HIGH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] high_in,
    input  logic [1:0]       mode_in,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_ack,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] cnt_out
);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    localparam logic [1:0] ModeSquare  = 2'd0;
    localparam logic [1:0] ModeOneShot = 2'd2;
    localparam logic [1:0] ModeIllegal = 2'd3;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             cfg_ack_q, cfg_ack_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic [1:0]       sh_mode_q, sh_mode_d;
    logic             pending_q, pending_d;

    logic             load_ok;
    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] heff;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        load_ok = load && (div_in >= CNT_W'(2)) && (mode_in != ModeIllegal) &&
                  ((mode_in == ModeSquare) || ((high_in != '0) && (high_in < div_in)));
        wrap    = (state_q == StRun) && (cnt_q == div_q - CNT_W'(1));
        // A load on the boundary edge itself re-captures and defers application.
        apply   = pending_q && !load_ok && ((state_q != StRun) || wrap);

        div_d     = div_q;
        high_d    = high_q;
        mode_d    = mode_q;
        sh_div_d  = sh_div_q;
        sh_high_d = sh_high_q;
        sh_mode_d = sh_mode_q;
        pending_d = pending_q;
        cfg_ack_d = apply;
        err_d     = err_q | (load & ~load_ok);

        if (apply) begin
            div_d     = sh_div_q;
            high_d    = sh_high_q;
            mode_d    = sh_mode_q;
            pending_d = 1'b0;
        end
        if (load_ok) begin
            sh_div_d  = div_in;
            sh_high_d = high_in;
            sh_mode_d = mode_in;
            pending_d = 1'b1;
        end

        heff    = (mode_d == ModeSquare) ? (div_d >> 1) : high_d;
        cnt_inc = wrap ? '0 : cnt_q + CNT_W'(1);

        state_d   = state_q;
        cnt_d     = '0;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;

        // Wrap decisions follow the mode of the period that is ending.
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d   = StRun;
                    clk_out_d = (heff != '0);
                end
            end
            StRun: begin
                if (wrap && (mode_q == ModeOneShot)) begin
                    state_d = StHold;
                end else if ((mode_q != ModeOneShot) && !en) begin
                    state_d = StIdle;
                end else begin
                    cnt_d     = cnt_inc;
                    clk_out_d = (cnt_inc < heff);
                    tick_d    = (cnt_inc == div_d - CNT_W'(1));
                end
            end
            StHold: begin
                if (!en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            cfg_ack_q <= 1'b0;
            err_q     <= 1'b0;
            div_q     <= CNT_W'(DEF_DIV);
            high_q    <= CNT_W'(DEF_HIGH);
            mode_q    <= ModeSquare;
            sh_div_q  <= '0;
            sh_high_q <= '0;
            sh_mode_q <= ModeSquare;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            cfg_ack_q <= cfg_ack_d;
            err_q     <= err_d;
            div_q     <= div_d;
            high_q    <= high_d;
            mode_q    <= mode_d;
            sh_div_q  <= sh_div_d;
            sh_high_q <= sh_high_d;
            sh_mode_q <= sh_mode_d;
            pending_q <= pending_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign cfg_ack = cfg_ack_q;
    assign busy    = (state_q == StRun);
    assign err     = err_q;
    assign cnt_out = cnt_q;

endmodule

// File: tb/tb_prog_clk_gen.sv
// Bench for prog_clk_gen: directed scenarios plus random traffic, every cycle compared
// against a phase-based behavioural model.
module tb_prog_clk_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] div_in = '0;
    logic [7:0] high_in = '0;
    logic [1:0] mode_in = '0;
    logic       clk_out, tick, cfg_ack, busy, err;
    logic [7:0] cnt_out;

    int n_checks = 0;
    int n_pass   = 0;

    prog_clk_gen #(
        .CNT_W   (8),
        .DEF_DIV (4),
        .DEF_HIGH(2)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .div_in (div_in),
        .high_in(high_in),
        .mode_in(mode_in),
        .clk_out(clk_out),
        .tick   (tick),
        .cfg_ack(cfg_ack),
        .busy   (busy),
        .err    (err),
        .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    // Model: a run state, the phase within the period, and active/shadow configs.
    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MHold = 2;

    int m_state, m_phase, m_div, m_high, m_mode;
    int s_div, s_high, s_mode;
    bit m_pend, m_ack, m_err;

    function automatic int m_heff();
        return (m_mode == 0) ? m_div / 2 : m_high;
    endfunction

    function automatic int exp_clk();
        return int'(m_state == MRun && m_phase < m_heff());
    endfunction

    function automatic int exp_tick();
        return int'(m_state == MRun && m_phase == m_div - 1);
    endfunction

    task automatic model_step();
        int  d, h, md, old_mode;
        bit  valid, at_end;
        if (rst) begin
            m_state = MIdle; m_phase = 0;
            m_div = 4; m_high = 2; m_mode = 0;
            s_div = 0; s_high = 0; s_mode = 0;
            m_pend = 0; m_ack = 0; m_err = 0;
            return;
        end
        d  = int'(div_in);
        h  = int'(high_in);
        md = int'(mode_in);
        valid = load && d >= 2 && md != 3 && (md == 0 || (h >= 1 && h <= d - 1));
        if (load && !valid) m_err = 1;
        at_end   = (m_state == MRun) && (m_phase == m_div - 1);
        old_mode = m_mode;
        m_ack    = 0;
        if (m_pend && !valid && (m_state != MRun || at_end)) begin
            m_div = s_div; m_high = s_high; m_mode = s_mode;
            m_pend = 0; m_ack = 1;
        end
        if (valid) begin
            s_div = d; s_high = h; s_mode = md; m_pend = 1;
        end
        case (m_state)
            MIdle: if (en) begin m_state = MRun; m_phase = 0; end
            MRun: begin
                if (at_end && old_mode == 2) begin
                    m_state = MHold; m_phase = 0;
                end else if (old_mode != 2 && !en) begin
                    m_state = MIdle; m_phase = 0;
                end else begin
                    m_phase = at_end ? 0 : m_phase + 1;
                end
            end
            default: if (!en) m_state = MIdle;
        endcase
    endtask

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("clk_out", int'(clk_out), exp_clk());
        check_eq("tick", int'(tick), exp_tick());
        check_eq("cfg_ack", int'(cfg_ack), int'(m_ack));
        check_eq("busy", int'(busy), int'(m_state == MRun));
        check_eq("err", int'(err), int'(m_err));
        check_eq("cnt_out", int'(cnt_out), m_phase);
    endtask

    task automatic do_load(input int d, input int h, input int md);
        load = 1'b1; div_in = 8'(d); high_in = 8'(h); mode_in = 2'(md);
        cycle();
        load = 1'b0;
    endtask

    initial begin
        logic [7:0] pat, tk;
        int         acks, highs, ticks;
        bit         found;

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check_eq("rst_clk_out", int'(clk_out), 0);
        check_eq("rst_busy", int'(busy), 0);

        // Default square, period 4
        en = 1'b1;
        pat = '0; tk = '0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            pat = {pat[6:0], clk_out};
            tk  = {tk[6:0], tick};
        end
        check_eq("def_clk_pattern", int'(pat), int'(8'b1100_1100));
        check_eq("def_tick_pattern", int'(tk), int'(8'b0001_0001));
        check_eq("def_busy", int'(busy), 1);

        // Load D=5 one cycle after a wrap; applied at the following wrap
        cycle();
        do_load(5, 0, 0);
        acks = 0; pat = '0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            acks += int'(cfg_ack);
            if (i >= 2 && i < 7) pat = {pat[6:0], clk_out};
        end
        check_eq("sq5_ack_count", acks, 1);
        check_eq("sq5_pattern", int'(pat), int'(8'b0001_1000));

        // PWM D=10 H=3, stop at cnt=5
        do_load(10, 3, 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (m_mode == 1 && m_state == MRun && m_phase == 5) found = 1;
        end
        check_eq("pwm_reach_cnt5", int'(found), 1);
        en = 1'b0;
        cycle();
        check_eq("pwm_stop_clk", int'(clk_out), 0);
        check_eq("pwm_stop_cnt", int'(cnt_out), 0);
        check_eq("pwm_stop_busy", int'(busy), 0);

        // One-shot D=6 H=2, two shots
        do_load(6, 2, 2);
        cycle();
        for (int shot = 0; shot < 2; shot++) begin
            en = 1'b1;
            highs = 0; ticks = 0;
            for (int i = 0; i < 20; i++) begin
                cycle();
                highs += int'(clk_out);
                ticks += int'(tick);
            end
            check_eq("shot_highs", highs, 2);
            check_eq("shot_ticks", ticks, 1);
            check_eq("shot_hold_busy", int'(busy), 0);
            en = 1'b0;
            cycle();
        end

        // Illegal loads: sticky err, no ack
        en = 1'b1;
        acks = 0;
        do_load(1, 0, 0);
        acks += int'(cfg_ack);
        do_load(5, 2, 3);
        acks += int'(cfg_ack);
        do_load(8, 8, 1);
        acks += int'(cfg_ack);
        for (int i = 0; i < 5; i++) begin
            cycle();
            acks += int'(cfg_ack);
        end
        check_eq("bad_ack_count", acks, 0);
        check_eq("bad_err_sticky", int'(err), 1);

        // Reset mid-period with a pending config
        en = 1'b0;
        cycle();
        en = 1'b1;
        cycle();
        cycle();
        do_load(9, 0, 0);
        rst = 1'b1;
        cycle();
        check_eq("mid_rst_clk", int'(clk_out), 0);
        check_eq("mid_rst_err", int'(err), 0);
        check_eq("mid_rst_cnt", int'(cnt_out), 0);
        rst = 1'b0;
        acks = 0; pat = '0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            acks += int'(cfg_ack);
            if (i < 8) pat = {pat[6:0], clk_out};
        end
        check_eq("mid_rst_no_ack", acks, 0);
        check_eq("mid_rst_default_pattern", int'(pat), int'(8'b1100_1100));

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) en = ~en;
            load = ($urandom_range(0, 7) == 0);
            div_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 12));
            high_in = 8'($urandom_range(0, 13));
            mode_in = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
